rgbw_sout: RTL

//  Serializes 32-bit RGBW words onto a single-wire WS2812b/SK6812 style output, MSB first, one bit per BIT_CLKS.

---
 rtl/rgbw_sout.sv | 96 +++++++++
 1 files changed

// File: rtl/rgbw_sout.sv
// rgbw_sout: serialise NBITS-bit RGBW words MSB-first as WS2812b/SK6812 pulses, with a stream-reset latch; ports clk, rst, in_data/in_valid/in_ready, latch_req, sout, busy, done
module rgbw_sout #(
  parameter int NBITS      = 32,
  parameter int BIT_CLKS   = 120,
  parameter int T0H_CLKS   = 29,
  parameter int T1H_CLKS   = 64,
  parameter int RESET_CLKS = 7680
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             latch_req,
  output logic             sout,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(RESET_CLKS + 1);
  localparam int IW = $clog2(NBITS);
  typedef enum logic [1:0] {IDLE, BIT, LATCH} state_t;
  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [IW-1:0]    idx, idx_n;
  logic [NBITS-1:0] sh, sh_n;
  logic             pend, pend_n, sout_n;
  logic             bit_end, last, lat_end, pend_any, take;
  assign bit_end  = state == BIT && cnt == CW'(BIT_CLKS - 1);
  assign last     = bit_end && idx == IW'(NBITS - 1);
  assign lat_end  = state == LATCH && cnt == CW'(RESET_CLKS - 1);
  assign pend_any = pend | latch_req;
  assign take     = in_valid & in_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      pend  <= 1'b0;
      sout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
      pend  <= pend_n;
      sout  <= sout_n;
      done  <= lat_end;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    pend_n  = lat_end ? 1'b0 : pend_any;
    case (state)
      IDLE: begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = pend_any ? LATCH : take ? BIT : IDLE;
        sh_n    = take ? in_data : sh;
      end
      BIT: begin
        if (!bit_end) begin
          cnt_n = cnt + 1'b1;
        end else if (!last) begin
          cnt_n = '0;
          idx_n = idx + 1'b1;
          sh_n  = sh << 1;
        end else begin
          cnt_n   = '0;
          idx_n   = '0;
          sh_n    = take ? in_data : sh;
          state_n = take ? BIT : pend_any ? LATCH : IDLE;
        end
      end
      LATCH: begin
        cnt_n   = lat_end ? '0 : cnt + 1'b1;
        state_n = lat_end ? IDLE : LATCH;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase
  end
  // sout is registered from the next-state view so it rises on the edge that enters a bit
  always_comb begin
    sout_n   = state_n == BIT && cnt_n < (sh_n[NBITS-1] ? CW'(T1H_CLKS) : CW'(T0H_CLKS));
    in_ready = ~rst & ~pend_any & (state == IDLE | last);
    busy     = state != IDLE;
  end
endmodule
